instruction_decode_queue: RTL and testbench

INSTRUCTION_DECODE_QUEUE -- requirements
Module: instruction_decode_queue

---
 rtl/decode_pkg.sv | 104 ++++++++++
 rtl/instr_fifo.sv | 56 +++++
 rtl/instruction_decode_queue.sv | 100 ++++++++++
 tb/tb_instruction_decode_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Opcode, select encodings and write-enable one-hots shared by decode and execute.
// The decode helper maps a raw opcode and its operand to the select bundle.
package decode_pkg;

  typedef enum logic [2:0] {
    OP_ADV = 3'd0,
    OP_BXL = 3'd1,
    OP_BST = 3'd2,
    OP_JNZ = 3'd3,
    OP_BXC = 3'd4,
    OP_OUT = 3'd5,
    OP_BDV = 3'd6,
    OP_CDV = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    OP1_REG_A = 2'd0,
    OP1_REG_B = 2'd1,
    OP1_COMBO = 2'd2
  } op1_e;

  typedef enum logic [1:0] {
    OP2_LIT   = 2'd0,
    OP2_REG_C = 2'd1
  } op2_e;

  typedef enum logic [1:0] {
    ALU_SHIFT = 2'd0,
    ALU_XOR   = 2'd1,
    ALU_MOD   = 2'd2,
    ALU_JUMP  = 2'd3
  } alu_e;

  localparam logic [4:0] WR_NONE = 5'b00000;
  localparam logic [4:0] WR_A    = 5'b00001;
  localparam logic [4:0] WR_B    = 5'b00010;
  localparam logic [4:0] WR_C    = 5'b00100;
  localparam logic [4:0] WR_OUT  = 5'b01000;
  localparam logic [4:0] WR_PC   = 5'b10000;

  typedef struct packed {
    op1_e       op1;
    op2_e       op2;
    alu_e       alu;
    logic [4:0] wr_en;
    logic       illegal;
  } dec_t;

  // Combo operand 7 is reserved, so any combo-consuming opcode flags it.
  function automatic dec_t decode(
    input logic [2:0] opcode,
    input logic [2:0] opnd
  );
    dec_t d;
    logic c7;
    d = '{op1: OP1_REG_A, op2: OP2_LIT, alu: ALU_SHIFT,
          wr_en: WR_NONE, illegal: 1'b0};
    c7 = (opnd == 3'd7);
    unique case (1'b1)
      opcode == OP_ADV: begin
        d.wr_en = WR_A;
        d.illegal = c7;
      end
      opcode == OP_BXL: begin
        d.op1 = OP1_REG_B;
        d.alu = ALU_XOR;
        d.wr_en = WR_B;
      end
      opcode == OP_BST: begin
        d.op1 = OP1_COMBO;
        d.alu = ALU_MOD;
        d.wr_en = WR_B;
        d.illegal = c7;
      end
      opcode == OP_JNZ: begin
        d.alu = ALU_JUMP;
        d.wr_en = WR_PC;
      end
      opcode == OP_BXC: begin
        d.op1 = OP1_REG_B;
        d.op2 = OP2_REG_C;
        d.alu = ALU_XOR;
        d.wr_en = WR_B;
      end
      opcode == OP_OUT: begin
        d.op1 = OP1_COMBO;
        d.alu = ALU_MOD;
        d.wr_en = WR_OUT;
        d.illegal = c7;
      end
      opcode == OP_BDV: begin
        d.wr_en = WR_B;
        d.illegal = c7;
      end
      opcode == OP_CDV: begin
        d.wr_en = WR_C;
        d.illegal = c7;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction buffer with wrap-around pointers and an occupancy count.
// Writes when full and reads when empty are ignored.
module instr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign do_wr   = wr_en && !full && !clr;
  assign do_rd   = rd_en && !empty && !clr;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_decode_queue.sv
// Fetch-to-execute instruction queue with a registered decode stage.
// An empty queue bypasses the incoming instruction straight to the output.
module instruction_decode_queue
  import decode_pkg::*;
#(
  parameter int OPW   = 3,
  parameter int DEPTH = 4,
  parameter int PCW   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   halt,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [2:0]             if_opcode,
  input  logic [OPW-1:0]         if_operand,
  input  logic [PCW-1:0]         if_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [OPW-1:0]         id_operand,
  output logic [PCW-1:0]         id_pc,
  output logic [1:0]             id_op1_sel,
  output logic [1:0]             id_op2_sel,
  output logic [1:0]             id_operation_sel,
  output logic [4:0]             id_reg_wr_en,
  output logic                   id_illegal,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int IW = 3 + OPW + PCW;

  logic [IW-1:0] in_word;
  logic [IW-1:0] head_word;
  logic [IW-1:0] ld_word;
  logic          q_empty;
  logic          q_full;
  logic          push;
  logic          load;
  logic          pop;
  logic          q_wr;
  logic          ld_any;
  dec_t          dec;

  assign in_word  = {if_opcode, if_operand, if_pc};
  assign if_ready = !halt && !q_full;
  assign push     = if_valid && if_ready && !flush;
  assign load     = !halt && !flush && (!id_valid || id_ready);
  assign pop      = load && !q_empty;
  assign q_wr     = push && !(load && q_empty);
  assign ld_word  = q_empty ? in_word : head_word;
  assign ld_any   = !q_empty || push;

  always_comb begin
    dec = decode(ld_word[IW-1 -: 3], ld_word[PCW +: 3]);
  end

  instr_fifo #(
    .WIDTH (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (q_wr),
    .wr_data (in_word),
    .rd_en   (pop),
    .rd_data (head_word),
    .count   (occupancy),
    .empty   (q_empty),
    .full    (q_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid         <= 1'b0;
      id_operand       <= '0;
      id_pc            <= '0;
      id_op1_sel       <= '0;
      id_op2_sel       <= '0;
      id_operation_sel <= '0;
      id_reg_wr_en     <= '0;
      id_illegal       <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (load) begin
      id_valid <= ld_any;
      if (ld_any) begin
        id_operand       <= ld_word[PCW +: OPW];
        id_pc            <= ld_word[PCW-1:0];
        id_op1_sel       <= dec.op1;
        id_op2_sel       <= dec.op2;
        id_operation_sel <= dec.alu;
        id_reg_wr_en     <= dec.wr_en;
        id_illegal       <= dec.illegal;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Scoreboard bench for instruction_decode_queue: expected decodes are queued
// on accepted pushes and compared against the output register while valid.
module tb_instruction_decode_queue;

  localparam int OPW   = 3;
  localparam int DEPTH = 4;
  localparam int PCW   = 8;
  localparam int XW    = OPW + PCW + 2 + 2 + 2 + 5 + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic                   halt = 1'b0;
  logic                   if_valid = 1'b0;
  logic                   if_ready;
  logic [2:0]             if_opcode = '0;
  logic [OPW-1:0]         if_operand = '0;
  logic [PCW-1:0]         if_pc = '0;
  logic                   id_valid;
  logic                   id_ready = 1'b0;
  logic [OPW-1:0]         id_operand;
  logic [PCW-1:0]         id_pc;
  logic [1:0]             id_op1_sel;
  logic [1:0]             id_op2_sel;
  logic [1:0]             id_operation_sel;
  logic [4:0]             id_reg_wr_en;
  logic                   id_illegal;
  logic [$clog2(DEPTH):0] occupancy;

  int n_checks = 0;
  int n_err = 0;
  logic [XW-1:0] sbq[$];
  logic [XW-1:0] obs;
  logic [PCW-1:0] pcn = '0;

  assign obs = {id_operand, id_pc, id_op1_sel, id_op2_sel,
                id_operation_sel, id_reg_wr_en, id_illegal};

  always #5 clk = ~clk;

  instruction_decode_queue #(
    .OPW   (OPW),
    .DEPTH (DEPTH),
    .PCW   (PCW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .halt             (halt),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_opcode        (if_opcode),
    .if_operand       (if_operand),
    .if_pc            (if_pc),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_operand       (id_operand),
    .id_pc            (id_pc),
    .id_op1_sel       (id_op1_sel),
    .id_op2_sel       (id_op2_sel),
    .id_operation_sel (id_operation_sel),
    .id_reg_wr_en     (id_reg_wr_en),
    .id_illegal       (id_illegal),
    .occupancy        (occupancy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [XW-1:0] expect_of(input logic [2:0] opc,
                                              input logic [OPW-1:0] opnd,
                                              input logic [PCW-1:0] pc);
    logic [1:0] o1, o2, al;
    logic [4:0] wr;
    logic il;
    logic c7;
    c7 = (opnd[2:0] == 3'd7);
    o1 = 0; o2 = 0; al = 0; wr = 0; il = 0;
    case (opc)
      3'd0: begin wr = 5'b00001; il = c7; end
      3'd1: begin o1 = 1; al = 1; wr = 5'b00010; end
      3'd2: begin o1 = 2; al = 2; wr = 5'b00010; il = c7; end
      3'd3: begin al = 3; wr = 5'b10000; end
      3'd4: begin o1 = 1; o2 = 1; al = 1; wr = 5'b00010; end
      3'd5: begin o1 = 2; al = 2; wr = 5'b01000; il = c7; end
      3'd6: begin wr = 5'b00010; il = c7; end
      default: begin wr = 5'b00100; il = c7; end
    endcase
    return {opnd, pc, o1, o2, al, wr, il};
  endfunction

  task automatic cyc(input logic iv, input logic [2:0] opc,
                     input logic [OPW-1:0] opnd, input logic rdy,
                     input logic hlt, input logic fl);
    int occ;
    @(negedge clk);
    if_valid   = iv;
    if_opcode  = opc;
    if_operand = opnd;
    if_pc      = pcn;
    id_ready   = rdy;
    halt       = hlt;
    flush      = fl;
    #1;
    occ = (sbq.size() > 1) ? sbq.size() - 1 : 0;
    check("occupancy", 32'(occupancy), 32'(occ));
    check("id_valid", 32'(id_valid), 32'(sbq.size() != 0));
    check("if_ready", 32'(if_ready), 32'(!hlt && occ < DEPTH));
    if (id_valid && sbq.size() != 0)
      check("id_word", 32'(obs), 32'(sbq[0]));
    if (!hlt && !fl && id_valid && id_ready && sbq.size() != 0)
      void'(sbq.pop_front());
    if (!hlt && !fl && iv && if_ready)
      sbq.push_back(expect_of(opc, opnd, pcn));
    if (fl) sbq.delete();
    pcn = pcn + 1'b1;
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, '0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_wr_en", 32'(id_reg_wr_en), 32'd0);
    check("rst_word", 32'(obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_if_ready", 32'(if_ready), 32'd1);

    // BXL operand 5 issues one cycle after push
    cyc(1'b1, 3'd1, 3'd5, 1'b1, 1'b0, 1'b0);
    #1;
    check("bxl_valid", 32'(id_valid), 32'd1);
    check("bxl_op1", 32'(id_op1_sel), 32'd1);
    check("bxl_op2", 32'(id_op2_sel), 32'd0);
    check("bxl_oper", 32'(id_operation_sel), 32'd1);
    check("bxl_wr", 32'(id_reg_wr_en), 32'b00010);
    check("bxl_operand", 32'(id_operand), 32'd5);
    idle(2, 1'b1);

    // fill with stalled execute side, overflow attempt, then drain
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 3'(i + 2), 3'(i), 1'b0, 1'b0, 1'b0);
    #1;
    check("full_occ", 32'(occupancy), 32'd4);
    check("full_ifready", 32'(if_ready), 32'd0);
    cyc(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    idle(7, 1'b1);
    check("drain_empty", 32'(sbq.size()), 32'd0);

    // illegal combo operand
    cyc(1'b1, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
    #1;
    check("adv7_ill", 32'(id_illegal), 32'd1);
    check("adv7_wr", 32'(id_reg_wr_en), 32'b00001);
    cyc(1'b1, 3'd1, 3'd7, 1'b1, 1'b0, 1'b0);
    #1;
    check("bxl7_ill", 32'(id_illegal), 32'd0);
    idle(2, 1'b1);

    // flush with three queued and a same-cycle push
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 3'd4, 3'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'd6, 3'd2, 1'b0, 1'b0, 1'b1);
    #1;
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_valid", 32'(id_valid), 32'd0);
    idle(3, 1'b1);

    // halt freezes everything with execute ready
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 3'd7, 3'(i + 1), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b1);

    // JNZ then OUT back to back
    cyc(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    #1;
    check("jnz_wr", 32'(id_reg_wr_en), 32'b10000);
    check("jnz_oper", 32'(id_operation_sel), 32'd3);
    cyc(1'b1, 3'd5, 3'd4, 1'b1, 1'b0, 1'b0);
    #1;
    check("out_wr", 32'(id_reg_wr_en), 32'b01000);
    check("out_op1", 32'(id_op1_sel), 32'd2);
    check("out_oper", 32'(id_operation_sel), 32'd2);
    idle(2, 1'b1);

    // reset mid-operation discards everything
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 3'd0, 3'(i), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    if_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(id_valid), 32'd0);
    check("mrst_occ", 32'(occupancy), 32'd0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 29) == 0));
    idle(8, 1'b1);
    check("final_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
